// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs between instruction memory and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_buffer
  import rv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t ent_q [2];
  fetch_entry_t ent_d [2];
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;
  logic [1:0]   wr_idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    do_pop  = pop & (count_q != 2'd0);
    wr_idx  = count_q - {1'b0, do_pop};
    do_push = push & (wr_idx < 2'd2);

    if (flush) begin
      // Entries keep their stale contents; only the occupancy is cleared.
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        ent_d[0] = ent_q[1];
      end
      if (do_push) begin
        ent_d[wr_idx[0]] = push_entry;
      end
      count_d = wr_idx + {1'b0, do_push};
    end
  end

  // NOTE: the storage entries are reset too, because the head is visible on
  // inst/inst_pc and must read as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign count = count_q;
  assign head  = ent_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the fetch PC, arbitrates redirect/halt
// against buffer space, and presents buffered instructions to decode.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_idle
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [1:0]   buf_count;
  logic         push, pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pop  = inst_valid & inst_ready;
  assign push = ~redirect_valid & ~halt_req &
                ((buf_count < 2'(BUF_DEPTH)) | pop);

  assign push_entry = '{pc: fetch_pc_q, inst: imem_dout};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head       (head)
  );

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (buf_count != 2'd0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign fetch_idle = halt_req & (buf_count == 2'd0);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator that drives the instruction memory's address port and consumes its asynchronous read data. It holds the fetch PC, issues one word address per cycle, and captures each {pc, instruction} pair into a 2-entry fetch buffer. The buffer feeds decode through a valid/ready handshake. It also supports PC redirect (branch/jump) and a halt request. It sits between the instruction memory and the decode stage of the RV32I core.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0
BUF_DEPTH, 2, fetch buffer entries; fixed at 2, other values unsupported

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; equals fetch_pc combinationally
imem_dout  input  32  instruction word returned asynchronously for imem_addr
redirect_valid  input  1  replace fetch PC this cycle and flush the buffer
redirect_pc  input  32  target PC; bits [1:0] are ignored and forced to 0
halt_req  input  1  level; while high, no new fetches are pushed
inst_valid  output  1  buffer head holds a valid instruction
inst  output  32  instruction at the buffer head
inst_pc  output  32  PC of the instruction at the buffer head
inst_ready  input  1  decode accepts the head; pop = inst_valid & inst_ready
fetch_idle  output  1  high when halt_req=1 and the buffer is empty

Behaviour:
- Reset (async, while high): fetch_pc=RESET_PC, count=0, both entries cleared to 0. Outputs: inst_valid=0, inst=0, inst_pc=0, fetch_idle=0, imem_addr=RESET_PC. No push occurs while reset is high. This leaves the memory free to self-initialise during reset.
- pop = inst_valid & inst_ready.
- push = !redirect_valid & !halt_req & (count<2 | pop).
- On push: entry gets {fetch_pc, imem_dout} sampled at the edge, and fetch_pc <= fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Memory aliasing: the memory decodes only addr[11:2]. fetch_pc is not masked, so aliasing every 4 KB is expected.
- Latency: a word addressed in cycle N is visible at the head in cycle N+1 if the buffer was empty. After reset release, inst_valid=1 on the first edge, with inst_pc=RESET_PC.
- Throughput: 1 instr/cycle sustained when inst_ready is held high.
- Simultaneous push and pop when full (count=2): allowed; count stays 2 and order is preserved FIFO.
- Pop when count=1 with no push: buffer goes empty and inst_valid=0 next cycle.
- Redirect: highest priority. On the edge, count=0 (both entries discarded, including any head being popped), fetch_pc <= {redirect_pc[31:2],2'b00}, no push. The first fetch from the target happens the next cycle, so the target appears at the head 2 edges after the redirect cycle.
- Redirect while halt_req=1: PC is updated and the buffer flushed; fetching resumes from the target once halt_req drops.
- halt_req: blocks pushes only. Pops continue, so the buffer drains. fetch_idle = halt_req & (count==0), combinational.
- inst/inst_pc read the head entry combinationally from registers. When count=0 they hold the last values and are don't-care.
- Reset asserted mid-stream: immediate clear regardless of in-flight handshake.
- States (implicit in count): EMPTY(0), ONE(1), FULL(2). Transitions follow push/pop above; redirect forces any state to EMPTY.

Decomposition:
- Package rv_fetch_pkg: RESET_PC_DEFAULT, INSTR_NOP=32'h0000_0013, PC_INC=4, and a fetch_entry_t struct {pc[31:0], inst[31:0]}.
- Sub-module fetch_buffer: a 2-entry FIFO with push/pop/flush, count, and head outputs. fetch_unit keeps the PC register and the push/redirect arbitration.

Test Plan:
- Reset release, memory with word k = 32'h1000_0000+k, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles with inst 1000_0000..1000_0003; no bubbles.
- inst_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 32'h8. Raise ready -> heads 0,4,8 in order, no loss or duplicate.
- Redirect to 32'h0000_0103 while head pc=8 is being popped -> pop discarded, buffer empty next cycle, imem_addr=32'h100, next inst_pc=32'h100 two edges later.
- halt_req=1 with full buffer, inst_ready=1 -> two pops, then inst_valid=0 and fetch_idle=1; imem_addr frozen. Drop halt -> fetching resumes at the frozen PC.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Assert reset asynchronously between edges with count=2 -> inst_valid falls immediately, imem_addr=RESET_PC before the next edge.
